// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_run_pkg;

    localparam int          CW_DEFAULT      = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 60000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        RUN,
        REPORT,
        DONE
    } run_state_t;

    // Program index width; a single-program build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host/CPU run handshake bundle between the run controller and its environment.
// Latency: n/a (wires only).
// Backpressure: none; Ack is a level from the CPU, Go a level from the host.
// Signals: go (host request), ack (CPU halted), start (CPU start), prog_idx,
// busy, cycle_count, count_valid, timed_out, done.
// master = run controller, slave = host/CPU side.
interface cpu_run_ctrl_if #(
    parameter int NUM_PROGS = 3,
    parameter int CW        = cpu_run_pkg::CW_DEFAULT
);
    localparam int IW = cpu_run_pkg::idx_width(NUM_PROGS);

    logic          go;
    logic          ack;
    logic          start;
    logic [IW-1:0] prog_idx;
    logic          busy;
    logic [CW-1:0] cycle_count;
    logic          count_valid;
    logic          timed_out;
    logic          done;

    modport master (
        input  go, ack,
        output start, prog_idx, busy, cycle_count, count_valid, timed_out, done
    );

    modport slave (
        output go, ack,
        input  start, prog_idx, busy, cycle_count, count_valid, timed_out, done
    );

endinterface

// File: rtl/run_cycle_counter.sv
// Saturating per-run cycle counter with a limit-hit flag.
// Latency: count_o/hit_o are combinational and already include the current cycle.
// Backpressure: none; counts whenever enable_i is high, saturates at limit_i.
// Ports: clk_i, rst_i, clear_i, enable_i, limit_i -> count_o, hit_o.
module run_cycle_counter
    import cpu_run_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] count_o,
    output logic          hit_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // count_o is the value the counter will hold after this edge, so the
    // controller can report "cycles including the one Ack was seen in"
    // without an extra pipeline stage.
    always_comb begin
        count_o = (cnt_q >= limit_i) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = count_o;
        end
    end

    assign hit_o = enable_i && !clear_i && (count_o >= limit_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: pulses Start per program, times each run to Ack, watchdogs hangs.
// Latency: Start rises 1 cycle after Go; report 1 cycle after Ack/timeout edge; Done 1 cycle later.
// Backpressure: Go ignored while busy; Ack ignored during Start.
// Ports: clk_i, rst_i (async, active-high), bus (cpu_run_ctrl_if.master).
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int          NUM_PROGS      = 3,
    parameter int          START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int          CW             = CW_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    cpu_run_ctrl_if.master bus
);

    localparam int            IW         = idx_width(NUM_PROGS);
    localparam int            SCW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_PROGS - 1);
    localparam logic [CW-1:0]  LIMIT      = CW'(TIMEOUT_CYCLES);

    run_state_t     state_q;
    logic           start_q;
    logic           busy_q;
    logic [IW-1:0]  prog_idx_q;
    logic [CW-1:0]  cycle_count_q;
    logic           count_valid_q;
    logic           timed_out_q;
    logic           done_q;
    logic [SCW-1:0] start_cnt_q;

    logic           cnt_clr;
    logic           cnt_en;
    logic [CW-1:0]  cnt_val;
    logic           cnt_hit;

    // Counter is cleared on the edge that enters START, so it sits at zero
    // when the first WAIT_LOW cycle begins counting.
    assign cnt_clr = ((state_q == IDLE) && bus.go) ||
                     ((state_q == REPORT) && (prog_idx_q != LAST_IDX));
    assign cnt_en  = (state_q == WAIT_LOW) || (state_q == RUN);

    run_cycle_counter #(.CW(CW)) u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .limit_i  (LIMIT),
        .count_o  (cnt_val),
        .hit_o    (cnt_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            prog_idx_q    <= '0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            timed_out_q   <= 1'b0;
            done_q        <= 1'b0;
            start_cnt_q   <= '0;
        end else begin
            count_valid_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        state_q     <= START;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        prog_idx_q  <= '0;
                        start_cnt_q <= '0;
                    end
                end
                START: begin
                    if (start_cnt_q == START_LAST) begin
                        start_q <= 1'b0;
                        state_q <= WAIT_LOW;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end
                WAIT_LOW, RUN: begin
                    // Watchdog wins over a coincident Ack; an Ack seen in
                    // WAIT_LOW is stale halt from the previous program.
                    if (cnt_hit || ((state_q == RUN) && bus.ack)) begin
                        state_q       <= REPORT;
                        count_valid_q <= 1'b1;
                        cycle_count_q <= cnt_val;
                        timed_out_q   <= cnt_hit;
                    end else if ((state_q == WAIT_LOW) && !bus.ack) begin
                        state_q <= RUN;
                    end
                end
                REPORT: begin
                    if (prog_idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        prog_idx_q  <= prog_idx_q + 1'b1;
                        state_q     <= START;
                        start_q     <= 1'b1;
                        start_cnt_q <= '0;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start       = start_q;
    assign bus.busy        = busy_q;
    assign bus.prog_idx    = prog_idx_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.done        = done_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Host-side run controller that drives the CPU's Start/Ack handshake from the other end.
- On a Go request it runs NUM_PROGS programs back to back.
- Per program: pulse Start, wait for the CPU to leave halt, count cycles until Ack, report the count, advance.
- Sits beside the CPU at top level and replaces the testbench-driven Start sequencing. It also provides a watchdog for programs that never halt.

Parameters:
- NUM_PROGS, 3, number of programs run per Go; ProgIdx counts 0..NUM_PROGS-1.
- START_CYCLES, 2, cycles Start is held high per program (≥1).
- TIMEOUT_CYCLES, 16'd60000, cycle count at which a run is abandoned (≥2).
- CW, 16, cycle counter width.

Ports:
- Clk  in  1  clock, posedge used.
- Reset  in  1  asynchronous, active-high reset.
- Go  in  1  level; sampled in IDLE; starts a batch of NUM_PROGS runs.
- Ack  in  1  CPU done flag (combinational in the CPU, may be high while Start is asserted).
- Start  out  1  CPU start, registered.
- ProgIdx  out  $clog2(NUM_PROGS) (min 1)  index of the current/last program.
- Busy  out  1  high from Go acceptance until DONE is left.
- CycleCount  out  CW  cycles of the last completed run, held until the next report.
- CountValid  out  1  one-cycle pulse when CycleCount/TimedOut update.
- TimedOut  out  1  qualifies the current CycleCount; 1 = run hit TIMEOUT_CYCLES.
- Done  out  1  one-cycle pulse after the last program's report.

Behaviour:
- All outputs registered.
- Reset (async, any state, including mid-run) forces:
  - state IDLE, Start=0, ProgIdx=0, Busy=0;
  - CycleCount=0, CountValid=0, TimedOut=0, Done=0;
  - internal counters=0.
- States: IDLE, START, WAIT_LOW, RUN, REPORT, DONE.
- IDLE: Go=1 → START.
  - Start=1 and Busy=1 from the next cycle; ProgIdx=0; cycle counter cleared.
- START: Start held high for exactly START_CYCLES cycles; then Start=0 → WAIT_LOW.
  - Ack is ignored in START.
- WAIT_LOW: waits for Ack=0, because the CPU may still present halt from a previous program.
  - Ack=0 → RUN.
- RUN: on Ack=1 → REPORT with TimedOut=0.
- Cycle counter:
  - cleared on entry to START;
  - increments by 1 each cycle spent in WAIT_LOW and RUN, including the cycle Ack is first sampled high;
  - CycleCount = counter value at that sampling edge.
- Watchdog: if the counter reaches TIMEOUT_CYCLES in WAIT_LOW or RUN → REPORT.
  - CycleCount=TIMEOUT_CYCLES, TimedOut=1.
  - Timeout has priority over a simultaneous Ack=1.
  - The counter never wraps.
- REPORT: one cycle, CountValid=1.
  - If ProgIdx==NUM_PROGS-1 → DONE.
  - Otherwise ProgIdx+1, counter cleared → START.
- DONE: one cycle, Done=1; Busy drops with it → IDLE. ProgIdx holds its last value.
- Go in IDLE the same cycle DONE exits: IDLE samples Go normally (one IDLE cycle minimum between batches).
- Go is ignored while Busy=1.
- Go held high continuously: batches repeat back-to-back, each with ProgIdx restarting at 0.
- NUM_PROGS=1: REPORT goes directly to DONE.

Decomposition:
- Shared package cpu_run_pkg holds:
  - the state enum type (run_state_t: IDLE, START, WAIT_LOW, RUN, REPORT, DONE);
  - CW default;
  - TIMEOUT default constant.
- One natural sub-module: run_cycle_counter.
  - Inputs: clear, enable, limit.
  - Outputs: saturating count, hit-limit flag.
  - Async active-high reset.

Test Plan:
- Basic run, NUM_PROGS=1, START_CYCLES=2: Go pulse; Ack=0 from the 1st WAIT_LOW cycle, Ack=1 after 10 RUN cycles.
  → Start high exactly 2 cycles; CountValid pulse with CycleCount=11, TimedOut=0; Done pulse next cycle; Busy low after.
- Stale halt: Ack held 1 through START and 3 WAIT_LOW cycles, then 0, then 1 after 5 RUN cycles.
  → no early report; CycleCount=9.
- Batch of 3 with run lengths 4, 7, 2 (RUN cycles before Ack).
  → three CountValid pulses, CycleCount=5, 8, 3 with ProgIdx=0, 1, 2; single Done after the third.
- Timeout, TIMEOUT_CYCLES=20: Ack never rises.
  → CountValid with CycleCount=20, TimedOut=1; controller advances to the next program.
- Timeout/Ack collision: Ack rises on the exact edge the counter reaches 20.
  → TimedOut=1, CycleCount=20.
- Reset mid-RUN of program 1 in a 3-program batch.
  → all outputs return to reset values asynchronously; no Done; a new Go restarts at ProgIdx=0.
